// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// The FSM state encodings, the reset PC and the idle instruction word live here.
package ifu_fetch_pkg;

    typedef enum logic [1:0] {
        IFU_S_REQ   = 2'd0,
        IFU_S_WAIT  = 2'd1,
        IFU_S_VALID = 2'd2,
        IFU_S_FAULT = 2'd3
    } ifu_state_e;

    localparam logic [31:0] IFU_RESET_PC  = 32'h8000_0000;
    localparam logic [31:0] IFU_NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

    function automatic logic ifu_is_aligned(input logic [1:0] lsb);
        return (lsb == 2'b00);
    endfunction

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, issues one memory request at a time,
// holds the fetched word for decode, and handles redirects and fault reporting.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = WIDTH'(IFU_RESET_PC),
    parameter logic [WIDTH-1:0] NOP_INSTR = WIDTH'(IFU_NOP_INSTR)
) (
    input  logic             clk,
    input  logic             rst,
    output logic             IFU_o_req_valid,
    output logic [WIDTH-1:0] IFU_o_req_addr,
    input  logic             MEM_i_req_ready,
    input  logic             MEM_i_rsp_valid,
    input  logic [WIDTH-1:0] MEM_i_rsp_data,
    input  logic             MEM_i_rsp_err,
    output logic             IFU_o_rsp_ready,
    output logic             IFU_o_valid,
    output logic [WIDTH-1:0] IFU_o_instr,
    output logic [WIDTH-1:0] IFU_o_pc,
    input  logic             IDU_i_ready,
    input  logic             EXU_i_redirect,
    input  logic [WIDTH-1:0] EXU_i_redirect_pc,
    output logic             IFU_o_misalign,
    output logic             IFU_o_bus_err
);

    ifu_state_e       state_reg, state_next;
    logic [WIDTH-1:0] pc_reg, pc_next;
    logic [WIDTH-1:0] instr_reg, instr_next;
    logic             kill_reg, kill_next;
    logic             misalign_reg, misalign_next;
    logic             bus_err_reg, bus_err_next;

    logic             req_fire;
    logic             in_flight;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IFU_S_REQ;
            pc_reg       <= RESET_PC;
            instr_reg    <= NOP_INSTR;
            kill_reg     <= 1'b0;
            misalign_reg <= 1'b0;
            bus_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            instr_reg    <= instr_next;
            kill_reg     <= kill_next;
            misalign_reg <= misalign_next;
            bus_err_reg  <= bus_err_next;
        end
    end

    // Handshake strobes are decoded from registered state only.
    assign IFU_o_req_valid = (state_reg == IFU_S_REQ) && rst;
    assign IFU_o_req_addr  = pc_reg;
    assign IFU_o_rsp_ready = (state_reg == IFU_S_WAIT) ||
                             ((state_reg == IFU_S_FAULT) && kill_reg);
    assign IFU_o_valid     = (state_reg == IFU_S_VALID);
    assign IFU_o_instr     = (state_reg == IFU_S_VALID) ? instr_reg : NOP_INSTR;
    assign IFU_o_pc        = pc_reg;
    assign IFU_o_misalign  = misalign_reg;
    assign IFU_o_bus_err   = bus_err_reg;

    assign req_fire = IFU_o_req_valid && MEM_i_req_ready;

    // A request is still owed a response after this edge if one is accepted now,
    // or one was pending and its response does not arrive this cycle.
    always_comb begin
        in_flight = 1'b0;
        case (state_reg)
            IFU_S_REQ:   in_flight = req_fire;
            IFU_S_WAIT:  in_flight = !MEM_i_rsp_valid;
            IFU_S_FAULT: in_flight = kill_reg && !MEM_i_rsp_valid;
            default:     in_flight = 1'b0;
        endcase
    end

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        instr_next    = instr_reg;
        kill_next     = kill_reg;
        misalign_next = misalign_reg;
        bus_err_next  = bus_err_reg;

        if (EXU_i_redirect) begin
            pc_next   = EXU_i_redirect_pc;
            kill_next = in_flight;
            if (!ifu_is_aligned(EXU_i_redirect_pc[1:0])) begin
                misalign_next = 1'b1;
                state_next    = IFU_S_FAULT;
            end else begin
                misalign_next = 1'b0;
                bus_err_next  = 1'b0;
                // Drain a stale response first so only one request is ever outstanding.
                state_next    = in_flight ? IFU_S_WAIT : IFU_S_REQ;
            end
        end else begin
            case (state_reg)
                IFU_S_REQ: begin
                    if (req_fire) begin
                        state_next = IFU_S_WAIT;
                    end
                end
                IFU_S_WAIT: begin
                    if (MEM_i_rsp_valid) begin
                        if (kill_reg) begin
                            kill_next  = 1'b0;
                            state_next = IFU_S_REQ;
                        end else if (MEM_i_rsp_err) begin
                            bus_err_next = 1'b1;
                            state_next   = IFU_S_FAULT;
                        end else begin
                            instr_next = MEM_i_rsp_data;
                            state_next = IFU_S_VALID;
                        end
                    end
                end
                IFU_S_VALID: begin
                    if (IDU_i_ready) begin
                        pc_next    = pc_reg + WIDTH'(4);
                        state_next = IFU_S_REQ;
                    end
                end
                IFU_S_FAULT: begin
                    if (kill_reg && MEM_i_rsp_valid) begin
                        kill_next = 1'b0;
                    end
                end
                default: begin
                    state_next = IFU_S_REQ;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    a_one_direction: assert property (@(posedge clk) disable iff (!rst)
        !(IFU_o_req_valid && IFU_o_rsp_ready));
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed testbench for ifu_fetch: every scenario task drives a fixed sequence
// and compares outputs against hand-computed values.
module tb_ifu_fetch;

    logic        clk;
    logic        rst;
    logic        IFU_o_req_valid;
    logic [31:0] IFU_o_req_addr;
    logic        MEM_i_req_ready;
    logic        MEM_i_rsp_valid;
    logic [31:0] MEM_i_rsp_data;
    logic        MEM_i_rsp_err;
    logic        IFU_o_rsp_ready;
    logic        IFU_o_valid;
    logic [31:0] IFU_o_instr;
    logic [31:0] IFU_o_pc;
    logic        IDU_i_ready;
    logic        EXU_i_redirect;
    logic [31:0] EXU_i_redirect_pc;
    logic        IFU_o_misalign;
    logic        IFU_o_bus_err;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    ifu_fetch dut (
        .clk               (clk),
        .rst               (rst),
        .IFU_o_req_valid   (IFU_o_req_valid),
        .IFU_o_req_addr    (IFU_o_req_addr),
        .MEM_i_req_ready   (MEM_i_req_ready),
        .MEM_i_rsp_valid   (MEM_i_rsp_valid),
        .MEM_i_rsp_data    (MEM_i_rsp_data),
        .MEM_i_rsp_err     (MEM_i_rsp_err),
        .IFU_o_rsp_ready   (IFU_o_rsp_ready),
        .IFU_o_valid       (IFU_o_valid),
        .IFU_o_instr       (IFU_o_instr),
        .IFU_o_pc          (IFU_o_pc),
        .IDU_i_ready       (IDU_i_ready),
        .EXU_i_redirect    (EXU_i_redirect),
        .EXU_i_redirect_pc (EXU_i_redirect_pc),
        .IFU_o_misalign    (IFU_o_misalign),
        .IFU_o_bus_err     (IFU_o_bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge, then return inputs to idle so each cycle is set explicitly.
    task automatic tick();
        @(posedge clk);
        #1;
        MEM_i_req_ready   = 1'b0;
        MEM_i_rsp_valid   = 1'b0;
        MEM_i_rsp_err     = 1'b0;
        MEM_i_rsp_data    = 32'h0;
        IDU_i_ready       = 1'b0;
        EXU_i_redirect    = 1'b0;
        EXU_i_redirect_pc = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        checks++; if (IFU_o_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b expected 0", IFU_o_req_valid); end
        checks++; if (IFU_o_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", IFU_o_valid); end
        checks++; if (IFU_o_instr !== NOP) begin errors++; $display("FAIL rst_instr: got %h expected %h", IFU_o_instr, NOP); end
        checks++; if ({IFU_o_misalign, IFU_o_bus_err} !== 2'b00) begin errors++; $display("FAIL rst_flags: got %b expected 00", {IFU_o_misalign, IFU_o_bus_err}); end
        checks++; if (IFU_o_rsp_ready !== 1'b0) begin errors++; $display("FAIL rst_rsp_ready: got %b expected 0", IFU_o_rsp_ready); end
        rst = 1'b1;
        #1;
        checks++; if (IFU_o_req_valid !== 1'b1 || IFU_o_req_addr !== 32'h8000_0000) begin errors++; $display("FAIL rst_release: got valid=%b addr=%h expected 1 80000000", IFU_o_req_valid, IFU_o_req_addr); end
        $display("test_reset done");
    endtask

    task automatic test_zero_wait();
        logic [31:0] data_tab [3];
        logic [31:0] addr;
        data_tab[0] = 32'h0010_0093;
        data_tab[1] = 32'h0020_0113;
        data_tab[2] = 32'h0030_0193;
        for (int k = 0; k < 3; k++) begin
            addr = 32'h8000_0000 + 32'(4 * k);
            MEM_i_req_ready = 1'b1;
            IDU_i_ready = 1'b1;
            checks++; if (IFU_o_req_valid !== 1'b1 || IFU_o_req_addr !== addr) begin errors++; $display("FAIL zw_req[%0d]: got valid=%b addr=%h expected 1 %h", k, IFU_o_req_valid, IFU_o_req_addr, addr); end
            checks++; if (IFU_o_valid !== 1'b0) begin errors++; $display("FAIL zw_valid_req[%0d]: got %b expected 0", k, IFU_o_valid); end
            tick();
            MEM_i_rsp_valid = 1'b1;
            MEM_i_rsp_data = data_tab[k];
            IDU_i_ready = 1'b1;
            checks++; if (IFU_o_rsp_ready !== 1'b1 || IFU_o_req_valid !== 1'b0 || IFU_o_valid !== 1'b0) begin errors++; $display("FAIL zw_wait[%0d]: got rsp_ready=%b req_valid=%b valid=%b expected 1 0 0", k, IFU_o_rsp_ready, IFU_o_req_valid, IFU_o_valid); end
            tick();
            IDU_i_ready = 1'b1;
            checks++; if (IFU_o_valid !== 1'b1 || IFU_o_instr !== data_tab[k] || IFU_o_pc !== addr) begin errors++; $display("FAIL zw_out[%0d]: got valid=%b instr=%h pc=%h expected 1 %h %h", k, IFU_o_valid, IFU_o_instr, IFU_o_pc, data_tab[k], addr); end
            tick();
            $display("fetch pc=%h instr=%h", addr, data_tab[k]);
        end
        checks++; if (IFU_o_req_addr !== 32'h8000_000C) begin errors++; $display("FAIL zw_next_addr: got %h expected 8000000c", IFU_o_req_addr); end
    endtask

    task automatic test_stall();
        test_reset();
        for (int c = 0; c < 4; c++) begin
            checks++; if (IFU_o_req_valid !== 1'b1 || IFU_o_req_addr !== 32'h8000_0000 || IFU_o_rsp_ready !== 1'b0) begin errors++; $display("FAIL stall[%0d]: got valid=%b addr=%h rsp_ready=%b expected 1 80000000 0", c, IFU_o_req_valid, IFU_o_req_addr, IFU_o_rsp_ready); end
            tick();
        end
        MEM_i_req_ready = 1'b1;
        tick();
        checks++; if (IFU_o_rsp_ready !== 1'b1 || IFU_o_req_valid !== 1'b0) begin errors++; $display("FAIL stall_accept: got rsp_ready=%b req_valid=%b expected 1 0", IFU_o_rsp_ready, IFU_o_req_valid); end
        MEM_i_rsp_valid = 1'b1;
        MEM_i_rsp_data = 32'h0040_0213;
        tick();
        checks++; if (IFU_o_valid !== 1'b1 || IFU_o_instr !== 32'h0040_0213) begin errors++; $display("FAIL stall_out: got valid=%b instr=%h expected 1 00400213", IFU_o_valid, IFU_o_instr); end
        IDU_i_ready = 1'b1;
        tick();
        checks++; if (IFU_o_req_addr !== 32'h8000_0004) begin errors++; $display("FAIL stall_next: got %h expected 80000004", IFU_o_req_addr); end
        $display("test_stall done");
    endtask

    task automatic test_redirect_wait();
        MEM_i_req_ready = 1'b1;
        tick();
        EXU_i_redirect = 1'b1;
        EXU_i_redirect_pc = 32'h8000_0100;
        tick();
        for (int c = 0; c < 2; c++) begin
            checks++; if (IFU_o_valid !== 1'b0 || IFU_o_rsp_ready !== 1'b1 || IFU_o_req_valid !== 1'b0) begin errors++; $display("FAIL rdw_wait[%0d]: got valid=%b rsp_ready=%b req_valid=%b expected 0 1 0", c, IFU_o_valid, IFU_o_rsp_ready, IFU_o_req_valid); end
            tick();
        end
        MEM_i_rsp_valid = 1'b1;
        MEM_i_rsp_data = 32'hDEAD_BEEF;
        tick();
        checks++; if (IFU_o_valid !== 1'b0 || IFU_o_instr !== NOP) begin errors++; $display("FAIL rdw_drop: got valid=%b instr=%h expected 0 %h", IFU_o_valid, IFU_o_instr, NOP); end
        checks++; if (IFU_o_req_valid !== 1'b1 || IFU_o_req_addr !== 32'h8000_0100) begin errors++; $display("FAIL rdw_next: got valid=%b addr=%h expected 1 80000100", IFU_o_req_valid, IFU_o_req_addr); end
        $display("test_redirect_wait done");
    endtask

    task automatic test_hold();
        MEM_i_req_ready = 1'b1;
        tick();
        MEM_i_rsp_valid = 1'b1;
        MEM_i_rsp_data = 32'h00A0_0093;
        tick();
        for (int c = 0; c < 5; c++) begin
            checks++; if (IFU_o_valid !== 1'b1 || IFU_o_instr !== 32'h00A0_0093 || IFU_o_pc !== 32'h8000_0100 || IFU_o_req_valid !== 1'b0) begin errors++; $display("FAIL hold[%0d]: got valid=%b instr=%h pc=%h req_valid=%b expected 1 00a00093 80000100 0", c, IFU_o_valid, IFU_o_instr, IFU_o_pc, IFU_o_req_valid); end
            tick();
        end
        IDU_i_ready = 1'b1;
        tick();
        checks++; if (IFU_o_valid !== 1'b0 || IFU_o_req_addr !== 32'h8000_0104) begin errors++; $display("FAIL hold_advance: got valid=%b addr=%h expected 0 80000104", IFU_o_valid, IFU_o_req_addr); end
        $display("test_hold done");
    endtask

    task automatic test_misalign();
        EXU_i_redirect = 1'b1;
        EXU_i_redirect_pc = 32'h8000_0102;
        tick();
        for (int c = 0; c < 3; c++) begin
            MEM_i_req_ready = 1'b1;
            checks++; if (IFU_o_misalign !== 1'b1 || IFU_o_req_valid !== 1'b0 || IFU_o_valid !== 1'b0 || IFU_o_rsp_ready !== 1'b0) begin errors++; $display("FAIL mis_fault[%0d]: got mis=%b req_valid=%b valid=%b rsp_ready=%b expected 1 0 0 0", c, IFU_o_misalign, IFU_o_req_valid, IFU_o_valid, IFU_o_rsp_ready); end
            tick();
        end
        EXU_i_redirect = 1'b1;
        EXU_i_redirect_pc = 32'h8000_0200;
        tick();
        checks++; if (IFU_o_misalign !== 1'b0 || IFU_o_req_valid !== 1'b1 || IFU_o_req_addr !== 32'h8000_0200) begin errors++; $display("FAIL mis_clear: got mis=%b req_valid=%b addr=%h expected 0 1 80000200", IFU_o_misalign, IFU_o_req_valid, IFU_o_req_addr); end
        MEM_i_req_ready = 1'b1;
        tick();
        MEM_i_rsp_valid = 1'b1;
        MEM_i_rsp_data = 32'h0050_0293;
        tick();
        checks++; if (IFU_o_valid !== 1'b1 || IFU_o_pc !== 32'h8000_0200 || IFU_o_instr !== 32'h0050_0293) begin errors++; $display("FAIL mis_fetch: got valid=%b pc=%h instr=%h expected 1 80000200 00500293", IFU_o_valid, IFU_o_pc, IFU_o_instr); end
        IDU_i_ready = 1'b1;
        tick();
        $display("test_misalign done");
    endtask

    task automatic test_bus_err();
        MEM_i_req_ready = 1'b1;
        tick();
        MEM_i_rsp_valid = 1'b1;
        MEM_i_rsp_err = 1'b1;
        MEM_i_rsp_data = 32'h1234_5678;
        tick();
        for (int c = 0; c < 3; c++) begin
            MEM_i_req_ready = 1'b1;
            IDU_i_ready = 1'b1;
            checks++; if (IFU_o_bus_err !== 1'b1 || IFU_o_valid !== 1'b0 || IFU_o_req_valid !== 1'b0 || IFU_o_instr !== NOP) begin errors++; $display("FAIL berr_fault[%0d]: got berr=%b valid=%b req_valid=%b instr=%h expected 1 0 0 %h", c, IFU_o_bus_err, IFU_o_valid, IFU_o_req_valid, IFU_o_instr, NOP); end
            tick();
        end
        rst = 1'b0;
        #1;
        checks++; if (IFU_o_bus_err !== 1'b0 || IFU_o_misalign !== 1'b0 || IFU_o_req_valid !== 1'b0 || IFU_o_instr !== NOP) begin errors++; $display("FAIL berr_reset: got berr=%b mis=%b req_valid=%b instr=%h expected 0 0 0 %h", IFU_o_bus_err, IFU_o_misalign, IFU_o_req_valid, IFU_o_instr, NOP); end
        tick();
        rst = 1'b1;
        #1;
        checks++; if (IFU_o_req_valid !== 1'b1 || IFU_o_req_addr !== 32'h8000_0000) begin errors++; $display("FAIL berr_restart: got valid=%b addr=%h expected 1 80000000", IFU_o_req_valid, IFU_o_req_addr); end
        $display("test_bus_err done");
    endtask

    task automatic test_back_to_back();
        // Redirect in the same cycle as a request handshake.
        MEM_i_req_ready = 1'b1;
        EXU_i_redirect = 1'b1;
        EXU_i_redirect_pc = 32'h8000_0300;
        tick();
        checks++; if (IFU_o_rsp_ready !== 1'b1 || IFU_o_req_valid !== 1'b0) begin errors++; $display("FAIL b2b_kill_wait: got rsp_ready=%b req_valid=%b expected 1 0", IFU_o_rsp_ready, IFU_o_req_valid); end
        MEM_i_rsp_valid = 1'b1;
        MEM_i_rsp_data = 32'hDEAD_BEEF;
        tick();
        checks++; if (IFU_o_valid !== 1'b0 || IFU_o_req_valid !== 1'b1 || IFU_o_req_addr !== 32'h8000_0300) begin errors++; $display("FAIL b2b_refetch: got valid=%b req_valid=%b addr=%h expected 0 1 80000300", IFU_o_valid, IFU_o_req_valid, IFU_o_req_addr); end
        // Misaligned redirect while a request is outstanding.
        MEM_i_req_ready = 1'b1;
        tick();
        EXU_i_redirect = 1'b1;
        EXU_i_redirect_pc = 32'h8000_0301;
        tick();
        checks++; if (IFU_o_misalign !== 1'b1 || IFU_o_rsp_ready !== 1'b1 || IFU_o_req_valid !== 1'b0) begin errors++; $display("FAIL b2b_mis_absorb: got mis=%b rsp_ready=%b req_valid=%b expected 1 1 0", IFU_o_misalign, IFU_o_rsp_ready, IFU_o_req_valid); end
        MEM_i_rsp_valid = 1'b1;
        MEM_i_rsp_data = 32'hDEAD_BEEF;
        tick();
        checks++; if (IFU_o_rsp_ready !== 1'b0 || IFU_o_misalign !== 1'b1 || IFU_o_valid !== 1'b0) begin errors++; $display("FAIL b2b_mis_drained: got rsp_ready=%b mis=%b valid=%b expected 0 1 0", IFU_o_rsp_ready, IFU_o_misalign, IFU_o_valid); end
        EXU_i_redirect = 1'b1;
        EXU_i_redirect_pc = 32'h8000_0400;
        tick();
        checks++; if (IFU_o_req_valid !== 1'b1 || IFU_o_req_addr !== 32'h8000_0400 || IFU_o_misalign !== 1'b0) begin errors++; $display("FAIL b2b_recover: got req_valid=%b addr=%h mis=%b expected 1 80000400 0", IFU_o_req_valid, IFU_o_req_addr, IFU_o_misalign); end
        // Redirect wins over decode acceptance in S_VALID.
        MEM_i_req_ready = 1'b1;
        tick();
        MEM_i_rsp_valid = 1'b1;
        MEM_i_rsp_data = 32'h0060_0313;
        tick();
        checks++; if (IFU_o_valid !== 1'b1 || IFU_o_pc !== 32'h8000_0400) begin errors++; $display("FAIL b2b_valid: got valid=%b pc=%h expected 1 80000400", IFU_o_valid, IFU_o_pc); end
        IDU_i_ready = 1'b1;
        EXU_i_redirect = 1'b1;
        EXU_i_redirect_pc = 32'h8000_0500;
        tick();
        checks++; if (IFU_o_valid !== 1'b0 || IFU_o_req_addr !== 32'h8000_0500) begin errors++; $display("FAIL b2b_priority: got valid=%b addr=%h expected 0 80000500", IFU_o_valid, IFU_o_req_addr); end
        // PC increment wraps at the top of the address space.
        EXU_i_redirect = 1'b1;
        EXU_i_redirect_pc = 32'hFFFF_FFFC;
        tick();
        checks++; if (IFU_o_req_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL b2b_wrap_req: got %h expected fffffffc", IFU_o_req_addr); end
        MEM_i_req_ready = 1'b1;
        tick();
        MEM_i_rsp_valid = 1'b1;
        MEM_i_rsp_data = 32'h0070_0393;
        tick();
        checks++; if (IFU_o_valid !== 1'b1 || IFU_o_pc !== 32'hFFFF_FFFC || IFU_o_instr !== 32'h0070_0393) begin errors++; $display("FAIL b2b_wrap_out: got valid=%b pc=%h instr=%h expected 1 fffffffc 00700393", IFU_o_valid, IFU_o_pc, IFU_o_instr); end
        IDU_i_ready = 1'b1;
        tick();
        checks++; if (IFU_o_req_valid !== 1'b1 || IFU_o_req_addr !== 32'h0000_0000) begin errors++; $display("FAIL b2b_wrap_next: got valid=%b addr=%h expected 1 00000000", IFU_o_req_valid, IFU_o_req_addr); end
        $display("test_back_to_back done");
    endtask

    initial begin
        rst               = 1'b0;
        MEM_i_req_ready   = 1'b0;
        MEM_i_rsp_valid   = 1'b0;
        MEM_i_rsp_data    = 32'h0;
        MEM_i_rsp_err     = 1'b0;
        IDU_i_ready       = 1'b0;
        EXU_i_redirect    = 1'b0;
        EXU_i_redirect_pc = 32'h0;

        test_reset();
        test_zero_wait();
        test_stall();
        test_redirect_wait();
        test_hold();
        test_misalign();
        test_bus_err();
        test_back_to_back();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch stage directly upstream of the decode stage. Owns the architectural PC.
- Fetches 32-bit instructions from instruction memory over a valid/ready request and response handshake with variable latency.
- Holds each fetched instruction and its PC stable until decode accepts it.
- Accepts redirects (branch, jump) from execute, drops stale responses, and reports misaligned-target and bus faults.

Parameters:
- WIDTH, 32, data and address width.
- RESET_PC, 32'h8000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, value driven on IFU_o_instr when no valid instruction is held (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- IFU_o_req_valid  out  1  fetch request valid.
- IFU_o_req_addr  out  WIDTH  fetch address (word aligned).
- MEM_i_req_ready  in  1  memory accepts the request.
- MEM_i_rsp_valid  in  1  response valid.
- MEM_i_rsp_data  in  WIDTH  instruction word.
- MEM_i_rsp_err  in  1  bus error for this response.
- IFU_o_rsp_ready  out  1  fetch stage accepts the response.
- IFU_o_valid  out  1  IFU_o_instr and IFU_o_pc are valid for decode.
- IFU_o_instr  out  WIDTH  instruction to decode.
- IFU_o_pc  out  WIDTH  PC of IFU_o_instr.
- IDU_i_ready  in  1  decode consumes the held instruction this cycle.
- EXU_i_redirect  in  1  redirect pulse.
- EXU_i_redirect_pc  in  WIDTH  redirect target.
- IFU_o_misalign  out  1  sticky: redirect target[1:0] was not 0.
- IFU_o_bus_err  out  1  sticky: response returned with error.

Behaviour:
- States: S_REQ, S_WAIT, S_VALID, S_FAULT. One outstanding request maximum. Redirect has priority over every other event.
- Reset (rst=0, asynchronous):
  - state=S_REQ, pc=RESET_PC, kill=0.
  - IFU_o_valid=0, IFU_o_instr=NOP_INSTR, both fault flags 0.
  - IFU_o_req_valid is forced 0 while rst=0.
  - Reset during S_WAIT abandons the request. A response arriving after reset release, while kill=0 and state=S_REQ, is ignored because IFU_o_rsp_ready=0 outside S_WAIT.
- S_REQ:
  - IFU_o_req_valid=1, IFU_o_req_addr=pc.
  - req_valid&&req_ready → S_WAIT.
  - Address stays stable while unaccepted, except when a redirect replaces it.
  - Redirect in a cycle with no handshake: pc←target, remain S_REQ.
  - Redirect in the same cycle as a handshake: pc←target, kill←1, → S_WAIT.
- S_WAIT:
  - IFU_o_rsp_ready=1, IFU_o_req_valid=0.
  - rsp_valid with kill=1: discard the response, kill←0, → S_REQ.
  - rsp_valid with err=1 (kill=0): bus_err←1, → S_FAULT.
  - rsp_valid otherwise: instr_buf←rsp_data, → S_VALID.
  - Redirect without rsp_valid: pc←target, kill←1.
  - Redirect with rsp_valid: pc←target, discard the response, → S_REQ.
- S_VALID:
  - IFU_o_valid=1; IFU_o_instr=instr_buf and IFU_o_pc=pc, both stable.
  - IDU_i_ready: pc←pc+4 (wraps modulo 2^WIDTH), → S_REQ.
  - Redirect: pc←target, → S_REQ. IDU_i_ready in the same cycle is ignored.
- Any state, redirect with target[1:0]≠0: misalign←1, pc←target, → S_FAULT, no request issued. If a request is outstanding, kill←1 and the later response is absorbed with IFU_o_rsp_ready=1.
- S_FAULT:
  - valid=0, req_valid=0, flags held.
  - Left only by an aligned redirect (flags cleared, → S_REQ) or by reset.
- IFU_o_instr = instr_buf when valid, otherwise NOP_INSTR.
- Latency with zero-wait memory (ready=1, response the cycle after acceptance):
  - request in cycle n, response in n+1, IFU_o_valid in n+2.
  - Throughput is 1 instruction per 3 cycles when IDU_i_ready=1.
- All registered outputs are glitch-free. IFU_o_req_valid and IFU_o_rsp_ready are decoded from state only.

Decomposition:
- Shared define header gets: state encodings (IFU_S_REQ..IFU_S_FAULT), RESET_PC, NOP_INSTR.
- No sub-module is needed; the PC register and the FSM stay in one module.

Test Plan:
- Reset release, zero-wait memory, IDU_i_ready=1:
  - req_addr sequence 8000_0000, 8000_0004, 8000_0008.
  - IFU_o_valid high in every third cycle.
  - IFU_o_pc matches the address that fetched the word.
- Memory ready held low for 4 cycles: req_valid=1 and req_addr=8000_0000 stable for all 4 cycles; no state change.
- Redirect to 8000_0100 during S_WAIT, response arriving 3 cycles later with data DEAD_BEEF:
  - the response is dropped and IFU_o_valid stays 0;
  - the next req_addr is 8000_0100.
- IDU_i_ready=0 for 5 cycles in S_VALID: IFU_o_instr and IFU_o_pc hold; no new request; pc advances by 4 only after ready.
- Redirect to 8000_0102:
  - IFU_o_misalign=1, no request issued.
  - A later redirect to 8000_0200 clears the flag and fetches 8000_0200.
- Response with err=1: IFU_o_bus_err=1, valid stays 0; then rst=0 mid-fault clears everything and fetch restarts at 8000_0000.
